// File: rtl/sudoku_board_loader.sv
// Streams one puzzle from the packed puzzle bank into the board RAM, one cell per beat,
// flagging out-of-range selects and corrupt solution digits.
module sudoku_board_loader #(
    parameter int NUM_PUZZLES = 15,
    parameter int CELLS       = 81
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PUZZLES*CELLS-1:0]     visibilities,
    input  logic [4*NUM_PUZZLES*CELLS-1:0]   maps,
    input  logic                             start,
    input  logic [3:0]                       puzzle_sel,
    output logic                             wr_valid,
    input  logic                             wr_ready,
    output logic [6:0]                       wr_addr,
    output logic [3:0]                       wr_digit,
    output logic [3:0]                       wr_solution,
    output logic                             wr_given,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [6:0]                       givens_count
);
    localparam int TOTAL = NUM_PUZZLES * CELLS;
    localparam int GW    = $clog2(TOTAL);
    localparam logic [6:0] LAST_ADDR = 7'(CELLS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t     state_reg;
    logic [3:0] sel_reg;

    logic [3:0]    lookup_sel;
    logic [6:0]    lookup_addr;
    logic [GW-1:0] lookup_g;
    logic [GW-1:0] lookup_rev;
    logic [3:0]    lookup_solution;
    logic          lookup_visible;
    logic          lookup_ok;

    // Look up the cell that would be presented on the next cycle: cell 0 of the
    // requested puzzle while idle, otherwise the cell after the current beat.
    always_comb begin
        lookup_sel  = sel_reg;
        lookup_addr = wr_addr + 7'd1;
        if (state_reg == IDLE) begin
            lookup_sel  = puzzle_sel;
            lookup_addr = 7'd0;
        end
        lookup_g        = GW'(lookup_sel) * GW'(CELLS) + GW'(lookup_addr);
        lookup_rev      = GW'(TOTAL - 1) - lookup_g;
        lookup_solution = maps[{lookup_rev, 2'b00} +: 4];
        lookup_visible  = visibilities[lookup_rev];
        lookup_ok       = (lookup_solution != 4'd0) && (lookup_solution <= 4'd9);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            sel_reg      <= 4'd0;
            wr_valid     <= 1'b0;
            wr_addr      <= 7'd0;
            wr_digit     <= 4'd0;
            wr_solution  <= 4'd0;
            wr_given     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            givens_count <= 7'd0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (puzzle_sel < 4'(NUM_PUZZLES)) begin
                            sel_reg      <= puzzle_sel;
                            wr_addr      <= 7'd0;
                            givens_count <= 7'd0;
                            if (lookup_ok) begin
                                state_reg   <= LOAD;
                                wr_valid    <= 1'b1;
                                busy        <= 1'b1;
                                wr_solution <= lookup_solution;
                                wr_given    <= lookup_visible;
                                wr_digit    <= lookup_visible ? lookup_solution : 4'd0;
                            end else begin
                                error <= 1'b1;
                            end
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (wr_ready) begin
                        givens_count <= givens_count + {6'd0, wr_given};
                        if (wr_addr == LAST_ADDR) begin
                            state_reg <= DONE;
                            wr_valid  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (lookup_ok) begin
                            wr_addr     <= wr_addr + 7'd1;
                            wr_solution <= lookup_solution;
                            wr_given    <= lookup_visible;
                            wr_digit    <= lookup_visible ? lookup_solution : 4'd0;
                        end else begin
                            // Corrupt digit: stop without rolling back earlier beats.
                            state_reg <= IDLE;
                            wr_valid  <= 1'b0;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sudoku_board_loader.sv
// Directed bench for sudoku_board_loader: normal, backpressured, rejected, corrupt,
// reset-aborted and all-visible loads checked beat by beat against a bank model.
module tb_sudoku_board_loader;
    logic          clk = 1'b0;
    logic          rst_n;
    logic [1214:0] visibilities;
    logic [4859:0] maps;
    logic          start;
    logic [3:0]    puzzle_sel;
    logic          wr_valid;
    logic          wr_ready;
    logic [6:0]    wr_addr;
    logic [3:0]    wr_digit;
    logic [3:0]    wr_solution;
    logic          wr_given;
    logic          busy;
    logic          done;
    logic          error;
    logic [6:0]    givens_count;

    logic [3:0] sol_mem [0:1214];
    logic       vis_mem [0:1214];
    int         checks = 0;
    int         failures = 0;
    int         givens;

    always #5 clk = ~clk;

    sudoku_board_loader dut (
        .clk(clk), .rst_n(rst_n), .visibilities(visibilities), .maps(maps),
        .start(start), .puzzle_sel(puzzle_sel), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_digit(wr_digit), .wr_solution(wr_solution),
        .wr_given(wr_given), .busy(busy), .done(done), .error(error),
        .givens_count(givens_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Bank contents: cell (0,0) is a visible 9, cell (0,5) a hidden 7.
    task automatic fill_bank(input bit all_visible);
        for (int p = 0; p < 15; p++) begin
            for (int i = 0; i < 81; i++) begin
                sol_mem[81*p + i] = 4'(((8 + 5*i + p) % 9) + 1);
                vis_mem[81*p + i] = all_visible ? 1'b1 : (((i + 2*p) % 3) != 2);
            end
        end
    endtask

    task automatic pack_bank();
        for (int g = 0; g < 1215; g++) begin
            maps[4859 - 4*g -: 4]    = sol_mem[g];
            visibilities[1214 - g]   = vis_mem[g];
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(wr_valid), 0);
        check_eq({tag, "_addr"}, 32'(wr_addr), 0);
        check_eq({tag, "_digit"}, 32'(wr_digit), 0);
        check_eq({tag, "_sol"}, 32'(wr_solution), 0);
        check_eq({tag, "_given"}, 32'(wr_given), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
        check_eq({tag, "_error"}, 32'(error), 0);
        check_eq({tag, "_count"}, 32'(givens_count), 0);
    endtask

    // One load of puzzle p. bad_cell / reset_at = -1 disables that event.
    task automatic do_load(input int p, input bit bp, input int bad_cell,
                           input int reset_at, input bit poke_start, output int cnt);
        int exp_addr;
        int cyc;
        int g;
        exp_addr = 0;
        cnt = 0;
        cyc = 1;
        @(posedge clk); #1;
        start = 1'b1; puzzle_sel = 4'(p); wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (exp_addr < 81 && cyc < 2000) begin
            wr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke_start && exp_addr == 20) begin
                start = 1'b1; puzzle_sel = 4'd9;
            end else begin
                start = 1'b0;
            end
            if (exp_addr == reset_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_all_zero("abort");
                $display("load p=%0d aborted by reset at beat %0d", p, exp_addr);
                return;
            end
            if (exp_addr == bad_cell) begin
                @(negedge clk);
                check_eq("bad_valid", 32'(wr_valid), 0);
                check_eq("bad_error", 32'(error), 1);
                check_eq("bad_busy", 32'(busy), 0);
                check_eq("bad_done", 32'(done), 0);
                $display("load p=%0d stopped at bad cell %0d after %0d beats", p, bad_cell, exp_addr);
                return;
            end
            @(negedge clk);
            g = 81*p + exp_addr;
            check_eq("valid", 32'(wr_valid), 1);
            check_eq("busy", 32'(busy), 1);
            check_eq("addr", 32'(wr_addr), 32'(exp_addr));
            check_eq("solution", 32'(wr_solution), 32'(sol_mem[g]));
            check_eq("given", 32'(wr_given), 32'(vis_mem[g]));
            check_eq("digit", 32'(wr_digit), vis_mem[g] ? 32'(sol_mem[g]) : 0);
            if (wr_ready) begin
                cnt += int'(vis_mem[g]);
                exp_addr++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        wr_ready = 1'b1;
        check_eq("beats_accepted", 32'(exp_addr), 81);
        if (!bp) check_eq("done_cycle", 32'(cyc), 82);
        @(negedge clk);
        check_eq("done_pulse", 32'(done), 1);
        check_eq("done_busy", 32'(busy), 0);
        check_eq("done_valid", 32'(wr_valid), 0);
        check_eq("done_count", 32'(givens_count), 32'(cnt));
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("done_once", 32'(done), 0);
        check_eq("count_hold", 32'(givens_count), 32'(cnt));
        $display("load p=%0d bp=%0d cycles=%0d givens=%0d", p, bp, cyc, givens_count);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; puzzle_sel = 4'd0; wr_ready = 1'b0;
        fill_bank(1'b0);
        pack_bank();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        $display("reset released");
        rst_n = 1'b1;

        do_load(0, 1'b0, -1, -1, 1'b0, givens);
        check_eq("p0_givens", 32'(givens_count), 54);

        do_load(3, 1'b1, -1, -1, 1'b0, givens);

        @(posedge clk); #1;
        start = 1'b1; puzzle_sel = 4'd15;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq("badsel_error", 32'(error), 1);
        check_eq("badsel_valid", 32'(wr_valid), 0);
        check_eq("badsel_busy", 32'(busy), 0);
        @(negedge clk);
        check_eq("badsel_error_once", 32'(error), 0);
        check_eq("badsel_valid_later", 32'(wr_valid), 0);
        check_eq("badsel_busy_later", 32'(busy), 0);
        $display("select 15 rejected");
        do_load(14, 1'b0, -1, -1, 1'b0, givens);

        sol_mem[2*81 + 40] = 4'd0;
        pack_bank();
        do_load(2, 1'b0, 40, -1, 1'b0, givens);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("bad_after_valid", 32'(wr_valid), 0);
            check_eq("bad_after_done", 32'(done), 0);
            check_eq("bad_after_busy", 32'(busy), 0);
            check_eq("bad_after_error", 32'(error), 0);
        end
        fill_bank(1'b0);
        pack_bank();

        do_load(6, 1'b0, -1, 30, 1'b1, givens);
        @(negedge clk);
        check_all_zero("abort_idle");
        do_load(6, 1'b0, -1, -1, 1'b0, givens);

        fill_bank(1'b1);
        pack_bank();
        do_load(5, 1'b0, -1, -1, 1'b0, givens);
        check_eq("allvis_givens", 32'(givens_count), 81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sudoku_board_loader.md
Name: sudoku_board_loader

Overview:
- Consumes the packed puzzle bank and streams one selected puzzle, cell by cell, into the board storage over a valid/ready write port.
- The bank is 15 puzzles; for each, 81 solution digits and 81 visibility bits.
- Writes the shown digit, the solution digit and the given flag for each cell, then reports the given count.
- Sits between the puzzle-definition ROM and the game-board RAM; triggered by the game controller on new game.

Parameters:
- NUM_PUZZLES, 15, number of puzzles in the bank; puzzle_sel values at or above this are rejected.
- CELLS, 81, cells per puzzle.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- visibilities  in  1215  visibility bank, 1 bit per cell, MSB-first
- maps  in  4860  solution bank, 4 bits per cell, MSB-first
- start  in  1  load request, single-cycle pulse, sampled in IDLE only
- puzzle_sel  in  4  puzzle index, latched on an accepted start
- wr_valid  out  1  write beat valid
- wr_ready  in  1  board RAM accepts beat
- wr_addr  out  7  cell index 0..80, row-major
- wr_digit  out  4  shown digit: solution if visible, else 0
- wr_solution  out  4  solution digit
- wr_given  out  1  visibility bit of the cell
- busy  out  1  high in LOAD
- done  out  1  one-cycle pulse after the last beat is accepted
- error  out  1  one-cycle pulse on a rejected select or a bad digit
- givens_count  out  7  number of visible cells; valid from done until the next accepted start

Behaviour:
- Indexing:
  - Global cell index g = 81*p + i.
  - Solution = maps[4859-4g -: 4].
  - Visible = visibilities[1214-g].
  - Cell 0 of puzzle 0 is therefore maps[4859:4856] and visibilities[1214].
- Reset (rst_n=0 at clk edge): state IDLE; all outputs 0, including wr_addr, givens_count, busy, done and error.
- All outputs are registered.
- IDLE:
  - start=1 with puzzle_sel < NUM_PUZZLES: latch sel, clear addr and count, go to LOAD.
  - start=1 with puzzle_sel >= NUM_PUZZLES: error=1 next cycle, no beats, stay IDLE.
- LOAD, beat presentation:
  - wr_valid=1 and busy=1.
  - Beat fields reflect cell wr_addr and are stable while wr_ready=0.
  - The first beat appears the cycle after start.
- LOAD, beat acceptance (wr_valid & wr_ready at an edge):
  - givens_count increments if wr_given=1.
  - If wr_addr=80: go to DONE, wr_valid=0.
  - Otherwise wr_addr+1 is presented the next cycle, so throughput is 1 beat/cycle.
- Digit check:
  - A solution digit of 0 or >9 on the presented cell is never put on the bus.
  - Instead: wr_valid=0, error pulse, return to IDLE; beats already written are not rolled back.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. givens_count holds.
- start while busy or in DONE is ignored.
- Timing with wr_ready tied high: start at cycle 0, beats at cycles 1..81, done at cycle 82.
- rst_n=0 mid-LOAD: abort immediately to the reset state; there is no done or error pulse.
- The maps and visibilities inputs are treated as static; changes during LOAD are not defined.

Test Plan:
- Puzzle 0 load, wr_ready=1, start at cycle 0 -> 81 beats at cycles 1..81, addrs 0..80 in order; addr 0 gives digit 9/solution 9/given 1; addr 5 gives digit 0/solution 7/given 0; done pulse at cycle 82; givens_count equals the popcount of visibilities[1214:1134] from the reference model.
- Backpressure: puzzle 3, wr_ready toggled pseudo-randomly (about 50%) -> every beat held stable while ready=0; exactly 81 accepts with no gaps or duplicates; all beat contents match the model.
- Invalid select: start with puzzle_sel=15 -> error=1 for one cycle; wr_valid never asserts; busy stays 0; next start with sel=14 loads normally.
- Bad digit: maps cell 40 of puzzle 2 forced to 0 -> 40 beats accepted (addrs 0..39); error pulse; no done; wr_valid=0 thereafter; state IDLE.
- Reset and start-ignore: start during LOAD is ignored (addr sequence unaffected); rst_n=0 at beat 30 -> all outputs 0 the next cycle; a fresh start reloads from addr 0 with givens_count restarted from 0.
- All-visible bank (visibilities all 1) -> every beat has wr_given=1 and wr_digit=wr_solution; givens_count=81 at done.
